// File: rtl/regfile16_onehot.sv
// 16-entry register file with a one-hot write port and two registered read ports.
// A built-in sequencer zeroes every entry over 16 cycles when a clear is requested.
module regfile16_onehot #(
    parameter int WIDTH   = 16,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      we,
    input  logic [WIDTH-1:0] wd,
    input  logic [3:0]       ra,
    input  logic [3:0]       rb,
    output logic [WIDTH-1:0] rda,
    output logic [WIDTH-1:0] rdb,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             err_multi,
    output logic             wr_drop
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_next;
    logic [3:0]       idx;
    logic [WIDTH-1:0] regs [16];

    logic [15:0]      we_low;
    logic             we_multi;
    logic             we_single;
    logic             wr_valid;
    logic             wr_ok;
    logic [3:0]       wa;
    logic [WIDTH-1:0] rda_next, rdb_next;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign we_low    = we & (we - 16'd1);
    assign we_multi  = |we_low;
    assign we_single = (|we) && !we_multi;
    assign wr_valid  = we_single && !(ZERO_R0 && we[0]);
    assign wr_ok     = wr_valid && (state == IDLE);
    assign clr_busy  = (state == CLEAR);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wa = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (we[k]) wa = 4'(k);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = CLEAR;
            CLEAR:   if (idx == 4'd15) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_next;
            idx   <= (state == CLEAR) ? idx + 4'd1 : 4'd0;
        end
    end

    // NOTE: the storage array is reset on purpose, since reset must leave every entry at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (wr_ok && (wa == 4'(k)))
                    regs[k] <= wd;
                else if ((state == CLEAR) && (idx == 4'(k)))
                    regs[k] <= '0;
            end
        end
    end

    // Read data reflects this edge's write or clear (write-first bypass).
    always_comb begin
        rda_next = regs[ra];
        if ((state == CLEAR) && (idx == ra)) rda_next = '0;
        if (wr_ok && (wa == ra))             rda_next = wd;
        if (ZERO_R0 && (ra == 4'd0))         rda_next = '0;
    end

    always_comb begin
        rdb_next = regs[rb];
        if ((state == CLEAR) && (idx == rb)) rdb_next = '0;
        if (wr_ok && (wa == rb))             rdb_next = wd;
        if (ZERO_R0 && (rb == 4'd0))         rdb_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rda       <= '0;
            rdb       <= '0;
            err_multi <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            rda       <= rda_next;
            rdb       <= rdb_next;
            err_multi <= we_multi;
            wr_drop   <= wr_valid && (state == CLEAR);
        end
    end

endmodule

// File: tb/tb_regfile16_onehot.sv
// Bench for regfile16_onehot: directed vector table, hand-written clear/reset
// sequences, and random traffic compared against a behavioural model.
module tb_regfile16_onehot;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] we;
    logic [15:0] wd;
    logic [3:0]  ra, rb;
    logic [15:0] rda, rdb;
    logic        clr_req;
    logic        clr_busy, err_multi, wr_drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile16_onehot #(.WIDTH(16), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wd(wd), .ra(ra), .rb(rb),
        .rda(rda), .rdb(rdb), .clr_req(clr_req), .clr_busy(clr_busy),
        .err_multi(err_multi), .wr_drop(wr_drop)
    );

    // Behavioural model: storage array plus "clear cycles remaining" counter.
    logic [15:0] mem [16];
    int          clr_left;
    int          clr_pos;
    logic [15:0] m_rda, m_rdb;
    logic        m_err, m_drop, m_busy;

    typedef struct {
        logic [15:0] we;
        logic [15:0] wd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] exp_rda;
        logic [15:0] exp_rdb;
        logic        exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        clr_left = 0;
        clr_pos  = 0;
        m_rda = 16'h0; m_rdb = 16'h0;
        m_err = 1'b0; m_drop = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_update(input logic [15:0] w, input logic [15:0] d,
                                input logic [3:0] a, input logic [3:0] b, input logic c);
        int  cnt;
        int  k;
        bit  valid;
        bit  clearing;
        cnt = $countones(w);
        k = -1;
        for (int i = 0; i < 16; i++) if (w[i]) k = i;
        valid    = (cnt == 1) && (k != 0);
        clearing = (clr_left > 0);
        m_err    = (cnt > 1);
        m_drop   = valid && clearing;
        if (valid && !clearing) mem[k] = d;
        if (clearing) begin
            mem[clr_pos] = 16'h0;
            clr_pos++;
            clr_left--;
        end else if (c) begin
            clr_left = 16;
            clr_pos  = 0;
        end
        m_busy = (clr_left > 0);
        m_rda  = (a == 4'd0) ? 16'h0 : mem[a];
        m_rdb  = (b == 4'd0) ? 16'h0 : mem[b];
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare against the model.
    task automatic step(input logic [15:0] w, input logic [15:0] d,
                        input logic [3:0] a, input logic [3:0] b, input logic c);
        we = w; wd = d; ra = a; rb = b; clr_req = c;
        @(posedge clk);
        #1;
        model_update(w, d, a, b, c);
        check("rda", 32'(rda), 32'(m_rda));
        check("rdb", 32'(rdb), 32'(m_rdb));
        check("err_multi", 32'(err_multi), 32'(m_err));
        check("wr_drop", 32'(wr_drop), 32'(m_drop));
        check("clr_busy", 32'(clr_busy), 32'(m_busy));
    endtask

    initial begin
        int busy_cycles;
        logic [15:0] w;
        logic [3:0]  a;
        logic        c;

        tbl[0] = '{16'h0008, 16'hBEEF, 4'd3,  4'd0, 16'hBEEF, 16'h0000, 1'b0};
        tbl[1] = '{16'h0000, 16'h0000, 4'd3,  4'd3, 16'hBEEF, 16'hBEEF, 1'b0};
        tbl[2] = '{16'h0001, 16'h1234, 4'd0,  4'd3, 16'h0000, 16'hBEEF, 1'b0};
        tbl[3] = '{16'h0020, 16'hA5A5, 4'd5,  4'd5, 16'hA5A5, 16'hA5A5, 1'b0};
        tbl[4] = '{16'h0004, 16'h1111, 4'd2,  4'd0, 16'h1111, 16'h0000, 1'b0};
        tbl[5] = '{16'h0010, 16'h2222, 4'd4,  4'd2, 16'h2222, 16'h1111, 1'b0};
        tbl[6] = '{16'h0014, 16'hFFFF, 4'd2,  4'd4, 16'h1111, 16'h2222, 1'b1};
        tbl[7] = '{16'h0000, 16'h0000, 4'd2,  4'd4, 16'h1111, 16'h2222, 1'b0};
        tbl[8] = '{16'h8000, 16'hCAFE, 4'd15, 4'd3, 16'hCAFE, 16'hBEEF, 1'b0};
        tbl[9] = '{16'hFFFF, 16'h0000, 4'd15, 4'd5, 16'hCAFE, 16'hA5A5, 1'b1};

        rst_n = 1'b0; we = '0; wd = '0; ra = '0; rb = '0; clr_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rda", 32'(rda), 32'h0);
        check("reset_busy", 32'(clr_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].ra, tbl[i].rb, 1'b0);
            check($sformatf("vec%0d_rda", i), 32'(rda), 32'(tbl[i].exp_rda));
            check($sformatf("vec%0d_rdb", i), 32'(rdb), 32'(tbl[i].exp_rdb));
            check($sformatf("vec%0d_err", i), 32'(err_multi), 32'(tbl[i].exp_err));
        end

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rda", 32'(rda), 32'h0);
        check("async_rst_rdb", 32'(rdb), 32'h0);
        check("async_rst_busy", 32'(clr_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(16'h0, 16'h0, 4'd3, 4'd15, 1'b0);
        check("post_rst_reg3", 32'(rda), 32'h0);
        step(16'h0, 16'h0, 4'd5, 4'd2, 1'b0);

        // Preload, then clear with a dropped write and a redundant request.
        for (int k = 1; k < 16; k++) step(16'h1 << k, 16'h1100 + 16'(k), 4'(k), 4'(k), 1'b0);
        step(16'h0, 16'h0, 4'd1, 4'd2, 1'b1);
        busy_cycles = clr_busy ? 1 : 0;
        for (int i = 1; i < 40; i++) begin
            w = (i == 3) ? 16'h0200 : 16'h0;
            a = (i == 3) ? 4'd9 : 4'(i);
            c = (i == 5);
            step(w, 16'h7777, a, 4'd9, c);
            if (i == 3) check("drop_during_clear", 32'(wr_drop), 32'h1);
            if (clr_busy) busy_cycles++;
        end
        check("busy_window", 32'(busy_cycles), 32'd16);
        for (int k = 0; k < 16; k++) begin
            step(16'h0, 16'h0, 4'(k), 4'(15 - k), 1'b0);
            check($sformatf("cleared_reg%0d", k), 32'(rda), 32'h0);
        end

        // Write and clear request in the same idle cycle.
        step(16'h0040, 16'h5555, 4'd6, 4'd6, 1'b1);
        check("write_with_clr", 32'(rda), 32'h5555);
        for (int i = 0; i < 20; i++) step(16'h0, 16'h0, 4'd6, 4'd6, 1'b0);
        check("write_with_clr_cleared", 32'(rda), 32'h0);

        // Reset at clear cycle 7.
        for (int k = 1; k < 16; k++) step(16'h1 << k, 16'hABC0 + 16'(k), 4'(k), 4'd0, 1'b0);
        step(16'h0, 16'h0, 4'd0, 4'd0, 1'b1);
        for (int i = 1; i < 7; i++) step(16'h0, 16'h0, 4'(i), 4'd12, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midclr_rst_busy", 32'(clr_busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(16'h0100, 16'h3C3C, 4'd8, 4'd12, 1'b0);
        check("midclr_write_rd", 32'(rda), 32'h3C3C);
        check("midclr_write_drop", 32'(wr_drop), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 3)      w = 16'h0;
            else if (sel < 8) w = 16'h1 << $urandom_range(0, 15);
            else              w = 16'($urandom);
            step(w, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 29) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile16_onehot.md
Name: regfile16_onehot

Overview:
- 16-entry register file; its write port consumes the 16-bit one-hot write-enable vector produced by the 4:16 decoder stage.
- Two registered read ports.
- Built-in clear sequencer zeroes all entries over 16 cycles on request.
- Sits between the instruction-decode/decoder stage and the datapath ALU operand registers.

Parameters:
- WIDTH, 16, data width of each register in bits.
- ZERO_R0, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- we  input  16  one-hot write enable from the 4:16 decoder; bit k selects register k.
- wd  input  WIDTH  write data.
- ra  input  4  read address, port A.
- rb  input  4  read address, port B.
- rda  output  WIDTH  registered read data, port A.
- rdb  output  WIDTH  registered read data, port B.
- clr_req  input  1  start clear sequence; sampled in IDLE only.
- clr_busy  output  1  high while the clear sequence runs.
- err_multi  output  1  one-cycle pulse: more than one bit of we was set.
- wr_drop  output  1  one-cycle pulse: a valid write was discarded because a clear was in progress.

Behaviour:

Reset:
- rst_n low immediately forces all 16 registers, rda, rdb, clr_busy, err_multi and wr_drop to 0.
- Reset forces the FSM to IDLE and the clear index to 0.
- Reset mid-clear aborts the sequence; all registers are still 0 by reset.

Write, evaluated at each rising clk:
- we == 0: no write.
- we has exactly one bit set, FSM in IDLE: reg[k] <= wd.
- If ZERO_R0 = 1 and k = 0, the write is discarded silently; err_multi and wr_drop stay 0.
- we has two or more bits set: no register written; err_multi = 1 for the following cycle only. This applies regardless of FSM state.
- Valid one-hot write while FSM in CLEAR: discarded; wr_drop = 1 for the following cycle.

Read:
- At each rising edge, rda <= value of reg[ra] as it stands after this edge's write. rdb uses rb in the same way.
- A same-cycle write to the read address is bypassed: rda/rdb show the new wd one cycle later. This gives 1-cycle read latency with write-first semantics.
- With ZERO_R0 = 1, reading address 0 always returns 0.

Clear FSM (states IDLE, CLEAR):
- IDLE, clr_req = 1: go to CLEAR, idx <= 0, clr_busy <= 1.
- CLEAR: each cycle reg[idx] <= 0 and idx increments. After the cycle with idx = 15, return to IDLE and clr_busy <= 0.
- The sequence takes exactly 16 cycles with clr_busy high.
- clr_req is ignored while in CLEAR; no restart and no queueing.
- Reads remain active during CLEAR. A read of the entry being cleared in this cycle returns 0 (write-first).
- clr_req and a valid write in the same IDLE cycle: the write is performed, then the clear begins next cycle. The written value is therefore later cleared.

Widths:
- No arithmetic is performed.
- err_multi detection is a population count > 1 on we, registered.

Test Plan:
- Reset: hold rst_n = 0 mid-cycle -> rda = rdb = 0, clr_busy = 0 asynchronously. After release, reading any address returns 0.
- Write/read: we = 16'h0008, wd = 16'hBEEF; next cycle ra = 3 -> rda = 16'hBEEF one cycle later. With ZERO_R0 = 1, we = 16'h0001, wd = 16'h1234 -> rda at ra = 0 reads 0.
- Bypass: in one cycle, we = 16'h0020, wd = 16'hA5A5, ra = 5, rb = 5 -> next cycle rda = rdb = 16'hA5A5.
- Multi-hot: preload reg2 = 16'h1111 and reg4 = 16'h2222; drive we = 16'h0014, wd = 16'hFFFF -> err_multi high for exactly 1 cycle. reg2 still 16'h1111, reg4 still 16'h2222.
- Clear: preload all registers nonzero; pulse clr_req -> clr_busy high for exactly 16 cycles. Then all registers read 0. A write of 16'h7777 to reg9 during cycle 3 of the clear -> wr_drop pulses and reg9 reads 0. A second clr_req mid-clear does not extend the busy window.
- Reset mid-clear: assert rst_n = 0 at clear cycle 7 -> FSM back in IDLE, clr_busy = 0. After release, one valid write succeeds and wr_drop = 0.
